// File: rtl/score_display.sv
// Binary score to 8-digit multiplexed 7-segment display: a sequential double-dabble
// converter feeds a glitch-free displayed BCD register that a free-running scanner walks.
`ifndef CLOCK_FREQ_HZ
`define CLOCK_FREQ_HZ 100_000_000
`endif

module score_display #(
  parameter int unsigned DigitPeriod  = `CLOCK_FREQ_HZ / 8000,
  parameter bit          BlankLeading = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int unsigned NumDigits = 8;
  localparam int unsigned CntW      = $clog2(DigitPeriod);
  localparam logic [CntW-1:0] CntLast  = CntW'(DigitPeriod - 1);
  localparam logic [31:0]     MaxScore = 32'd99_999_999;

  typedef enum logic [1:0] {
    Idle,
    Load,
    Shift,
    Commit
  } state_e;

  state_e         state_q;
  logic           busy_q;
  logic [31:0]    lastValue_q;
  logic [31:0]    bin_q;
  logic [31:0]    bcd_q;
  logic [4:0]     shiftCnt_q;
  logic [31:0]    dispBcd_q;
  logic [CntW-1:0] refreshCnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     an_q;
  logic [6:0]     seg_q;

  logic [31:0]    bcdAdj_d;
  logic [63:0]    shift_d;
  logic [3:0]     curNib_d;
  logic           blanked_d;

  function automatic logic [6:0] segEncode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  // Double-dabble step: nibbles >= 5 get +3 so the following left shift carries correctly.
  always_comb begin
    bcdAdj_d = bcd_q;
    for (int i = 0; i < NumDigits; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcdAdj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    shift_d = {bcdAdj_d, bin_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= Idle;
      busy_q      <= 1'b0;
      lastValue_q <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      shiftCnt_q  <= '0;
      dispBcd_q   <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (value != lastValue_q) begin
            state_q <= Load;
            busy_q  <= 1'b1;
          end
        end
        Load: begin
          bin_q       <= (value > MaxScore) ? MaxScore : value;
          lastValue_q <= value;
          bcd_q       <= '0;
          shiftCnt_q  <= '0;
          state_q     <= Shift;
        end
        Shift: begin
          bcd_q      <= shift_d[63:32];
          bin_q      <= shift_d[31:0];
          shiftCnt_q <= shiftCnt_q + 5'd1;
          if (shiftCnt_q == 5'd31) begin
            state_q <= Commit;
          end
        end
        Commit: begin
          dispBcd_q <= bcd_q;
          busy_q    <= 1'b0;
          state_q   <= Idle;
        end
        default: begin
          state_q <= Idle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A digit above 0 is blanked when it and every more significant nibble are zero.
  always_comb begin
    curNib_d  = dispBcd_q[idx_q*4 +: 4];
    blanked_d = BlankLeading && (idx_q != 3'd0) &&
                ((dispBcd_q >> {idx_q, 2'b00}) == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refreshCnt_q <= '0;
      idx_q        <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
    end else begin
      if (refreshCnt_q == CntLast) begin
        refreshCnt_q <= '0;
        idx_q        <= idx_q + 3'd1;
      end else begin
        refreshCnt_q <= refreshCnt_q + 1'b1;
      end
      if (blanked_d) begin
        an_q  <= 8'hFF;
        seg_q <= 7'h7F;
      end else begin
        an_q  <= ~(8'b1 << idx_q);
        seg_q <= segEncode(curNib_d);
      end
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = busy_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: table of scores with hand-computed BCD and lit-digit
// masks, plus sequences for mid-conversion value change and reset during conversion.
module tb_score_display;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;
  logic        busy, busy2;

  int assertions = 0;
  int failures   = 0;
  int edgeCount  = 0;

  typedef struct {
    string       name;
    logic [31:0] value;
    logic [31:0] expBcd;
    logic [7:0]  expLit;
  } vector_t;

  vector_t vectors[6];

  score_display #(.DigitPeriod(4), .BlankLeading(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value),
    .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  score_display #(.DigitPeriod(4), .BlankLeading(1'b0)) dutNoBlank (
    .clk(clk), .rst(rst), .value(value),
    .an(an2), .seg(seg2), .dp(dp2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; output after edge n shows slot ((n-1)/4) mod 8.
  always @(posedge clk) begin
    if (rst) edgeCount = 0;
    else     edgeCount = edgeCount + 1;
  end

  function automatic logic [6:0] segCode(input logic [3:0] nib);
    case (nib)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    @(negedge clk);
    value = v;
  endtask

  task automatic measureBusy(input string name);
    int waitCnt;
    int highCnt;
    waitCnt = 0;
    while (!busy && waitCnt < 6) begin
      @(negedge clk);
      waitCnt++;
    end
    highCnt = 0;
    while (busy && highCnt < 100) begin
      highCnt++;
      @(negedge clk);
    end
    checkOutput({name, "_busyLen"}, highCnt, 34);
  endtask

  // One full 32-cycle frame on both instances; the unblanked one lights every digit.
  task automatic checkFrame(input string name, input logic [31:0] bcd, input logic [7:0] lit,
                            input logic expBusy);
    int slot;
    logic [7:0] expAn;
    logic [6:0] expSeg;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      slot = ((edgeCount - 1) / 4) % 8;
      expAn  = lit[slot] ? ~(8'b1 << slot) : 8'hFF;
      expSeg = lit[slot] ? segCode(bcd[slot*4 +: 4]) : 7'h7F;
      checkOutput({name, "_blank"}, {15'd0, an, seg, dp, busy}, {15'd0, expAn, expSeg, 1'b1, expBusy});
      checkOutput({name, "_noBlank"}, {15'd0, an2, seg2, dp2, busy2},
                  {15'd0, ~(8'b1 << slot), segCode(bcd[slot*4 +: 4]), 1'b1, expBusy});
    end
  endtask

  initial begin
    int highCnt;
    int waitCnt;

    vectors[0] = '{"v1234",    32'd1234,         32'h0000_1234, 8'h0F};
    vectors[1] = '{"vAllOnes", 32'hFFFF_FFFF,    32'h9999_9999, 8'hFF};
    vectors[2] = '{"vJustOver",32'd100_000_000,  32'h9999_9999, 8'hFF};
    vectors[3] = '{"v10M",     32'd10_000_000,   32'h1000_0000, 8'hFF};
    vectors[4] = '{"v1005",    32'd1005,         32'h0000_1005, 8'h0F};
    vectors[5] = '{"v7",       32'd7,            32'h0000_0007, 8'h01};

    rst   = 1'b1;
    value = 32'd0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("resetState", {15'd0, an, seg, dp, busy}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    rst = 1'b0;
    checkFrame("zeroHeld", 32'd0, 8'h01, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].value);
      measureBusy(vectors[i].name);
      checkFrame(vectors[i].name, vectors[i].expBcd, vectors[i].expLit, 1'b0);
    end

    // Value change during conversion: 5 finishes first, then 70 is picked up.
    applyStimulus(32'd5);
    waitCnt = 0;
    while (!busy && waitCnt < 6) begin
      @(negedge clk);
      waitCnt++;
    end
    highCnt = 0;
    while (busy && highCnt < 100) begin
      highCnt++;
      if (highCnt == 10) value = 32'd70;
      @(negedge clk);
    end
    checkOutput("midChange_busyLen", highCnt, 34);
    checkFrame("midChangeOld", 32'h0000_0005, 8'h01, 1'b1);
    waitCnt = 0;
    while (busy && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("midChange_done", {31'd0, busy}, 32'd0);
    checkFrame("midChangeNew", 32'h0000_0070, 8'h03, 1'b0);

    // Reset in the middle of the shift phase, then re-conversion of the held value.
    applyStimulus(32'd4321);
    waitCnt = 0;
    while (!busy && waitCnt < 6) begin
      @(negedge clk);
      waitCnt++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midReset", {15'd0, an, seg, dp, busy}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    checkOutput("midResetNoBlank", {15'd0, an2, seg2, dp2, busy2}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    measureBusy("afterReset");
    checkFrame("afterReset", 32'h0000_4321, 8'h0F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
